// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the Memory data port A arbiter.
//
// Contents:
//   ArbStates  - arbiter FSM states: ARB (free round-robin), LOCK0 / LOCK1
//                (port held by requester 0 / 1 for a burst).
//   REQ_CPU    - requester index of the CPU load/store stage.
//   REQ_DBG    - requester index of the debug/boot loader.
//   req_onehot - turns a requester index into a one-hot grant vector.
package MemArbPackage;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } ArbStates;

    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

    // Index 0 -> 2'b01, index 1 -> 2'b10.
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/memory_modes_pkg.sv
// Memory access modes shared by the Memory block and the blocks that drive it.
// This is the existing codebase package, carried in this slice so that the
// arbiter compiles on its own. Do not edit it here; edit the original.
//
// Contents:
//   ReadWriteModes - 3-bit access mode seen on the Memory writeMode and
//                    readMode lines. NONE means no access on that line.
package MemoryModesPackage;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        BYTE      = 3'd1,
        HALFWORD  = 3'd2,
        WORD      = 3'd3,
        WORDLEFT  = 3'd4,
        WORDRIGHT = 3'd5
    } ReadWriteModes;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input round-robin picker, purely combinational.
//
// Ports:
//   req [1:0] - request per input
//   ptr       - input that wins when both request (0 or 1)
//   gnt [1:0] - one-hot winner; 2'b00 when nothing requests
//
// The picker holds no state. The owner of the pointer decides when to
// advance it. That keeps the picker reusable for other two-master buses.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares Memory data port A between the CPU load/store stage (requester 0)
// and the debug/boot loader (requester 1).
//
// Arbitration is round-robin. A requester can hold the port for a burst by
// raising lock_i. The hold is bounded: after MAX_LOCK consecutive locked
// grants, a waiting requester gets the port.
// The granted requester's fields go straight onto the Memory control lines.
// Read data comes back one cycle later. A registered tag steers rvalid to
// the requester that issued the load.
//
// Ports:
//   clk, rst          - clock; asynchronous active-low reset
//   req_i[1:0]        - request valid per requester
//   lock_i[1:0]       - keep the port after this transfer (burst)
//   write_i[1:0]      - 1 = store, 0 = load
//   mode_i[1:0]       - ReadWriteModes value per requester
//   unsigned_i[1:0]   - unsigned load flag per requester
//   addr_i[1:0]       - byte address per requester (passed through unchanged)
//   wdata_i[1:0]      - store data per requester
//   gnt_o[1:0]        - one-hot grant, combinational, same cycle as request
//   rvalid_o[1:0]     - load data valid, one cycle after the granted load
//   rdata_o           - load data shared by both requesters
//   mem_*             - Memory port A control and data lines
//   mem_dataOutput    - Memory read data, valid the cycle after issue
//   dbg_state         - current arbiter FSM state, for observation only
//
// Handshake: a requester raises req_i[i] and holds every field except lock_i
// stable until it sees gnt_o[i] high. The transfer completes in that same
// cycle. A new request can be granted in the very next cycle, with no bubble.
// lock_i may change in any cycle; it is sampled in each cycle the FSM
// evaluates it.
//
// CNT_W must satisfy 2**CNT_W > MAX_LOCK so that the hold counter can
// reach MAX_LOCK.
module mem_port_arbiter
    import MemoryModesPackage::*;
    import MemArbPackage::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_LOCK = 16,
    parameter int CNT_W    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_i,
    input  logic [1:0]             lock_i,
    input  logic [1:0]             write_i,
    input  logic [1:0][2:0]        mode_i,
    input  logic [1:0]             unsigned_i,
    input  logic [1:0][ADDR_W-1:0] addr_i,
    input  logic [1:0][31:0]       wdata_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             rvalid_o,
    output logic [31:0]            rdata_o,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [31:0]            mem_data,
    output logic [2:0]             mem_writeMode,
    output logic [2:0]             mem_readMode,
    output logic                   mem_unsignedLoad,
    input  logic [31:0]            mem_dataOutput,
    output ArbStates               dbg_state
);

    // ------------------------------------------------------------------
    // Arbiter state
    // ------------------------------------------------------------------
    ArbStates         state, state_n;
    logic             rr_ptr, rr_ptr_n;       // requester favoured on a tie
    logic [CNT_W-1:0] lock_cnt, lock_cnt_n;   // grants taken under the current lock

    logic [1:0]       arb_pick;               // round-robin winner in ARB
    logic [1:0]       gnt_n;                  // grant decided this cycle
    logic             owner;                  // lock holder while in LOCK0/LOCK1
    logic             other;                  // the requester that is locked out
    logic             at_limit;               // lock holder has used its full hold

    // ------------------------------------------------------------------
    // Read-return tracking
    // ------------------------------------------------------------------
    logic             gnt_idx;                // index of the granted requester
    logic             load_issue;             // a real load goes to Memory this cycle
    logic             rd_tag_vld;
    logic             rd_tag;
    logic [31:0]      rdata_q;                // last returned load data

    assign owner    = (state == LOCK1);
    assign other    = ~owner;
    assign at_limit = (lock_cnt == CNT_W'(MAX_LOCK));

    rr_pick2 u_pick (
        .req (req_i),
        .ptr (rr_ptr),
        .gnt (arb_pick)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB;
            rr_ptr   <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            lock_cnt <= lock_cnt_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        lock_cnt_n = lock_cnt;
        gnt_n      = 2'b00;

        case (state)
            ARB: begin
                gnt_n = arb_pick;
                if ((arb_pick != 2'b00) && lock_i[arb_pick[1]]) begin
                    state_n    = arb_pick[1] ? LOCK1 : LOCK0;
                    lock_cnt_n = CNT_W'(1);
                end
            end

            LOCK0, LOCK1: begin
                if (at_limit && req_i[other]) begin
                    // Hold time used up and the other side is waiting. Give up
                    // the port with no grant this cycle. Point round-robin at
                    // the waiter so it wins the next ARB cycle even if the
                    // holder requests again.
                    state_n    = ARB;
                    lock_cnt_n = '0;
                    rr_ptr_n   = other;
                end else if (!lock_i[owner]) begin
                    // Lock released. A request still pending gets one last
                    // grant on the way out.
                    state_n    = ARB;
                    lock_cnt_n = '0;
                    if (req_i[owner]) begin
                        gnt_n = req_onehot(owner);
                    end
                end else if (req_i[owner]) begin
                    gnt_n = req_onehot(owner);
                    // Saturate at the limit. The lock only breaks once the
                    // other requester actually asks for the port.
                    if (!at_limit) begin
                        lock_cnt_n = lock_cnt + CNT_W'(1);
                    end
                end
                // Lock held but no request: wait in place, counter unchanged.
            end

            default: begin
                state_n    = ARB;
                lock_cnt_n = '0;
            end
        endcase

        // After any grant, the other requester gets the tie next time.
        if (gnt_n != 2'b00) begin
            rr_ptr_n = ~gnt_n[1];
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (grant and Memory drive)
    // ------------------------------------------------------------------
    assign gnt_idx = gnt_n[1];

    always_comb begin
        gnt_o            = 2'b00;
        mem_address      = '0;
        mem_data         = '0;
        mem_writeMode    = NONE;
        mem_readMode     = NONE;
        mem_unsignedLoad = 1'b0;

        // The grant is combinational from req_i. Gate it with rst so that
        // nothing reaches Memory while the block is held in reset.
        if (rst && (gnt_n != 2'b00)) begin
            gnt_o            = gnt_n;
            mem_address      = addr_i[gnt_idx];
            mem_data         = wdata_i[gnt_idx];
            mem_unsignedLoad = unsigned_i[gnt_idx];
            if (write_i[gnt_idx]) begin
                mem_writeMode = mode_i[gnt_idx];
            end else begin
                mem_readMode  = mode_i[gnt_idx];
            end
        end
    end

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Read return: tag the issuing requester, route data back next cycle
    // ------------------------------------------------------------------
    assign load_issue = (gnt_o != 2'b00) && !write_i[gnt_idx] &&
                        (mode_i[gnt_idx] != NONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_tag_vld <= 1'b0;
            rd_tag     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rd_tag_vld <= load_issue;
            if (load_issue) begin
                rd_tag <= gnt_idx;
            end
            if (rd_tag_vld) begin
                rdata_q <= mem_dataOutput;
            end
        end
    end

    // Memory data arrives in the return cycle and goes straight out. rdata_q
    // keeps the last returned word so that rdata_o holds between returns.
    assign rvalid_o = rd_tag_vld ? req_onehot(rd_tag) : 2'b00;
    assign rdata_o  = rd_tag_vld ? mem_dataOutput : rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// The bench models two requesters and a Memory that answers one cycle after
// a read. A reference model tracks the lock owner, the hold count and the
// round-robin turn, and predicts each cycle's grant and Memory lines.
// Each predicted load return goes into exp_q. A separate monitor pops and
// compares whenever the DUT asserts rvalid_o.
module tb_mem_port_arbiter;
    import MemoryModesPackage::*;
    import MemArbPackage::*;

    localparam int ADDR_W   = 32;
    localparam int MAX_LOCK = 4;
    localparam int CNT_W    = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [1:0]             req_i, lock_i, write_i, unsigned_i;
    logic [1:0][2:0]        mode_i;
    logic [1:0][ADDR_W-1:0] addr_i;
    logic [1:0][31:0]       wdata_i;
    logic [1:0]             gnt_o, rvalid_o;
    logic [31:0]            rdata_o;
    logic [ADDR_W-1:0]      mem_address;
    logic [31:0]            mem_data;
    logic [2:0]             mem_writeMode, mem_readMode;
    logic                   mem_unsignedLoad;
    logic [31:0]            mem_dataOutput = 32'h0;
    ArbStates               dbg_state;

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .MAX_LOCK (MAX_LOCK),
        .CNT_W    (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_i            (req_i),
        .lock_i           (lock_i),
        .write_i          (write_i),
        .mode_i           (mode_i),
        .unsigned_i       (unsigned_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .gnt_o            (gnt_o),
        .rvalid_o         (rvalid_o),
        .rdata_o          (rdata_o),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .mem_writeMode    (mem_writeMode),
        .mem_readMode     (mem_readMode),
        .mem_unsignedLoad (mem_unsignedLoad),
        .mem_dataOutput   (mem_dataOutput),
        .dbg_state        (dbg_state)
    );

    // Memory contents, as seen through the 16 address bits Memory decodes.
    function automatic logic [31:0] mem_fn(input logic [ADDR_W-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
    endfunction

    // Behavioural Memory: read data one cycle after issue, junk otherwise.
    always @(posedge clk) begin
        if (mem_readMode != 3'(NONE)) mem_dataOutput <= mem_fn(mem_address);
        else                          mem_dataOutput <= $urandom;
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Scoreboard entry: {due cycle[64:33], tag[32], data[31:0]}
    logic [64:0] exp_q[$];
    logic [31:0] last_rdata = 32'h0;

    // ---------------- requester model ----------------
    logic [1:0]             r_req, r_lock, r_write, r_uns, r_repeat, granted;
    logic [1:0][2:0]        r_mode;
    logic [1:0][ADDR_W-1:0] r_addr;
    logic [1:0][31:0]       r_wdata;

    // ---------------- reference model ----------------
    int m_owner;   // -1 when the port is free, else the lock holder
    int m_cnt;     // grants taken by the lock holder in this lock
    int m_ptr;     // requester that wins a tie

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    // Returns the requester granted this cycle (-1 for none) and advances the model.
    task automatic model_step(output int w);
        int o;
        w = -1;
        if (m_owner < 0) begin
            if (req_i[0] && req_i[1]) w = m_ptr;
            else if (req_i[0])        w = 0;
            else if (req_i[1])        w = 1;
            if (w >= 0 && lock_i[w]) begin
                m_owner = w;
                m_cnt   = 1;
            end
        end else begin
            o = 1 - m_owner;
            if (m_cnt == MAX_LOCK && req_i[o]) begin
                m_owner = -1;
                m_ptr   = o;
            end else if (!lock_i[m_owner]) begin
                if (req_i[m_owner]) w = m_owner;
                m_owner = -1;
            end else if (req_i[m_owner]) begin
                w = m_owner;
                if (m_cnt < MAX_LOCK) m_cnt++;
            end
        end
        if (w >= 0) m_ptr = 1 - w;
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply();
        req_i      = r_req;
        lock_i     = r_lock;
        write_i    = r_write;
        unsigned_i = r_uns;
        mode_i     = r_mode;
        addr_i     = r_addr;
        wdata_i    = r_wdata;
    endtask

    task automatic clear_reqs();
        r_req    = 2'b00;
        r_lock   = 2'b00;
        r_repeat = 2'b00;
        granted  = 2'b00;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [2:0] md,
                           input logic lk, input logic rep, input logic [31:0] ad);
        r_req[i]    = 1'b1;
        r_write[i]  = wr;
        r_mode[i]   = md;
        r_lock[i]   = lk;
        r_repeat[i] = rep;
        r_addr[i]   = ad;
        r_uns[i]    = 1'($urandom_range(0, 1));
        r_wdata[i]  = $urandom;
        granted[i]  = 1'b0;
    endtask

    task automatic new_fields(input int i);
        r_write[i] = 1'($urandom_range(0, 1));
        r_mode[i]  = 3'($urandom_range(0, 5));
        r_uns[i]   = 1'($urandom_range(0, 1));
        r_addr[i]  = $urandom;
        r_wdata[i] = $urandom;
    endtask

    // Compare this cycle's outputs against the model and queue any load return.
    task automatic check_cycle();
        int         w;
        logic [1:0] eg;
        ArbStates   es;
        es = (m_owner < 0) ? ARB : ((m_owner == 0) ? LOCK0 : LOCK1);
        model_step(w);
        eg = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
        chk("gnt", 64'(gnt_o), 64'(eg));
        chk("state", 64'(dbg_state), 64'(es));
        if (w >= 0) begin
            chk("mem_address", 64'(mem_address), 64'(addr_i[w]));
            chk("mem_data", 64'(mem_data), 64'(wdata_i[w]));
            chk("mem_unsigned", 64'(mem_unsignedLoad), 64'(unsigned_i[w]));
            chk("mem_writeMode", 64'(mem_writeMode), write_i[w] ? 64'(mode_i[w]) : 64'(NONE));
            chk("mem_readMode", 64'(mem_readMode), write_i[w] ? 64'(NONE) : 64'(mode_i[w]));
            granted[w] = 1'b1;
            if (!write_i[w] && mode_i[w] != 3'(NONE))
                exp_q.push_back({32'(cyc + 1), 1'(w), mem_fn(addr_i[w])});
        end else begin
            chk("idle_address", 64'(mem_address), 64'h0);
            chk("idle_data", 64'(mem_data), 64'h0);
            chk("idle_writeMode", 64'(mem_writeMode), 64'(NONE));
            chk("idle_readMode", 64'(mem_readMode), 64'(NONE));
        end
    endtask

    // One clock: retire granted requests, optionally randomise, drive, check.
    task automatic run_cycle(input bit rnd);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (granted[i]) begin
                granted[i] = 1'b0;
                if (r_repeat[i]) begin
                    r_addr[i]  = $urandom;
                    r_wdata[i] = $urandom;
                end else begin
                    r_req[i] = 1'b0;
                end
            end
            if (rnd) begin
                if (!r_req[i] && $urandom_range(0, 2) == 0) begin
                    r_req[i] = 1'b1;
                    new_fields(i);
                end
                if ($urandom_range(0, 7) == 0) r_lock[i] = ~r_lock[i];
            end
        end
        apply();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic reset_checks();
        chk("rst_gnt", 64'(gnt_o), 64'h0);
        chk("rst_rvalid", 64'(rvalid_o), 64'h0);
        chk("rst_rdata", 64'(rdata_o), 64'h0);
        chk("rst_writeMode", 64'(mem_writeMode), 64'(NONE));
        chk("rst_readMode", 64'(mem_readMode), 64'(NONE));
        chk("rst_address", 64'(mem_address), 64'h0);
        chk("rst_data", 64'(mem_data), 64'h0);
        chk("rst_unsigned", 64'(mem_unsignedLoad), 64'h0);
        chk("rst_state", 64'(dbg_state), 64'(ARB));
    endtask

    // Put the bench side back to its reset picture while rst is low.
    task automatic bench_reset();
        model_reset();
        exp_q.delete();
        last_rdata = 32'h0;
        clear_reqs();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            while (exp_q.size() > 0 && int'(exp_q[0][64:33]) < cyc) begin
                checks++;
                $display("FAIL rvalid_missing @cycle %0d: got rvalid 0 expected tag %0d due %0d",
                         cyc, exp_q[0][32], int'(exp_q[0][64:33]));
                void'(exp_q.pop_front());
            end
            if (rvalid_o != 2'b00) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL rvalid_unexpected @cycle %0d: got rvalid %b expected 00", cyc, rvalid_o);
                end else begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    chk("rvalid_cycle", 64'(cyc), 64'(e[64:33]));
                    chk("rvalid_tag", 64'(rvalid_o), e[32] ? 64'h2 : 64'h1);
                    chk("rdata", 64'(rdata_o), 64'(e[31:0]));
                    last_rdata = e[31:0];
                end
            end else begin
                chk("rdata_hold", 64'(rdata_o), 64'(last_rdata));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        r_write = '0; r_uns = '0; r_mode = '0; r_addr = '0; r_wdata = '0;
        bench_reset();
        rst = 1'b0;
        // Requests held high during reset must not reach Memory.
        set_req(0, 1'b0, 3'(WORD), 1'b0, 1'b0, 32'h40);
        set_req(1, 1'b1, 3'(BYTE), 1'b1, 1'b0, 32'h80);
        apply();
        #12;
        reset_checks();
        clear_reqs();
        apply();
        @(negedge clk);
        rst = 1'b1;

        // CPU-only WORD load from 0x10.
        set_req(REQ_CPU, 1'b0, 3'(WORD), 1'b0, 1'b0, 32'h0000_0010);
        run_cycle(0);
        run_cycle(0);
        // A single DBG store moves the round-robin turn back to the CPU.
        set_req(REQ_DBG, 1'b1, 3'(WORD), 1'b0, 1'b0, 32'h0000_0020);
        run_cycle(0);
        run_cycle(0);

        // Both requesters streaming stores, no lock: grants alternate.
        set_req(REQ_CPU, 1'b1, 3'(WORD), 1'b0, 1'b1, 32'h100);
        set_req(REQ_DBG, 1'b1, 3'(HALFWORD), 1'b0, 1'b1, 32'h200);
        repeat (4) run_cycle(0);
        clear_reqs();
        run_cycle(0);

        // DBG locked burst with the CPU waiting: hold limit, gap, CPU wins.
        set_req(REQ_DBG, 1'b1, 3'(WORD), 1'b1, 1'b1, 32'h300);
        run_cycle(0);
        set_req(REQ_CPU, 1'b1, 3'(BYTE), 1'b0, 1'b1, 32'h400);
        repeat (7) run_cycle(0);
        clear_reqs();
        repeat (2) run_cycle(0);

        // Lock released while the DBG request is still pending.
        set_req(REQ_DBG, 1'b0, 3'(WORD), 1'b1, 1'b1, 32'h500);
        run_cycle(0);
        set_req(REQ_CPU, 1'b0, 3'(HALFWORD), 1'b0, 1'b1, 32'h600);
        run_cycle(0);
        r_lock[REQ_DBG] = 1'b0;
        repeat (3) run_cycle(0);
        clear_reqs();
        repeat (2) run_cycle(0);

        // Back-to-back loads from both requesters: returns must be steered.
        set_req(REQ_CPU, 1'b0, 3'(WORD), 1'b0, 1'b0, 32'h0000_1234);
        set_req(REQ_DBG, 1'b0, 3'(BYTE), 1'b0, 1'b0, 32'h0000_ABCD);
        repeat (4) run_cycle(0);

        // Async reset in the cycle after a granted load: the return is dropped.
        set_req(REQ_CPU, 1'b0, 3'(WORD), 1'b0, 1'b0, 32'h0000_0777);
        run_cycle(0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        bench_reset();
        r_req = 2'b11;
        apply();
        #1;
        reset_checks();
        r_req = 2'b00;
        apply();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) run_cycle(0);

        // Randomised traffic against the model.
        clear_reqs();
        repeat (2500) run_cycle(1);

        // Drain outstanding returns.
        clear_reqs();
        repeat (3) run_cycle(0);
        chk("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares data port A of the Memory block between two requesters: requester 0 is the CPU load/store stage; requester 1 is the debug/boot loader.
- Arbitrates round-robin, with an optional bus lock for burst transfers. The lock has a bounded hold time.
- Drives the Memory control lines (address, data, writeMode, readMode, unsignedLoad) directly.
- Memory read data appears one cycle after issue; the block tags the issuing requester and routes that data back to it.

Parameters:
- ADDR_W, 32, width of the requester address and of the memory address.
- MAX_LOCK, 16, maximum consecutive grants a locked requester may hold while the other requester waits.
- CNT_W, 5, width of the lock-hold counter; must satisfy 2^CNT_W > MAX_LOCK.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_i  in  2  request valid, per requester
- lock_i  in  2  hold the grant after this transfer, per requester
- write_i  in  2  1 = store, 0 = load
- mode_i  in  2x3  ReadWriteModes value (NONE/BYTE/HALFWORD/WORD/WORDLEFT/WORDRIGHT)
- unsigned_i  in  2  unsigned load flag
- addr_i  in  2xADDR_W  byte address
- wdata_i  in  2x32  store data
- gnt_o  out  2  one-hot; request accepted this cycle (combinational)
- rvalid_o  out  2  load data valid, one cycle after grant
- rdata_o  out  32  load data, shared by both requesters
- mem_address  out  ADDR_W  to Memory address
- mem_data  out  32  to Memory data
- mem_writeMode  out  3  to Memory writeMode
- mem_readMode  out  3  to Memory readMode
- mem_unsignedLoad  out  1  to Memory unsignedLoad
- mem_dataOutput  in  32  from Memory dataOutput

Behaviour:
- Reset (rst low, asynchronous):
  - FSM enters ARB; rr_ptr = 0; lock_cnt = 0; rd_tag_vld = 0.
  - gnt_o = 0, rvalid_o = 0, rdata_o = 0.
  - mem_writeMode and mem_readMode = NONE; mem_address, mem_data and mem_unsignedLoad = 0.
- Handshake:
  - A requester holds req and all its fields stable until it sees gnt_o high.
  - A transfer completes in the cycle gnt is high. Back-to-back grants are allowed every cycle; there is no bubble.
- Memory drive:
  - When gnt[i] is high, mem_* take requester i's fields.
  - Store: mem_writeMode = mode_i, mem_readMode = NONE.
  - Load: mem_readMode = mode_i, mem_writeMode = NONE.
  - When no grant is active, both modes are NONE and the other mem_* lines are 0.
- Read return:
  - On a granted load whose mode is not NONE, register rd_tag = i and rd_tag_vld = 1.
  - The next cycle: rvalid_o[rd_tag] = 1 and rdata_o = mem_dataOutput.
  - Stores and NONE-mode requests produce no rvalid.
  - rdata_o holds its last value when rvalid_o is 0.
- FSM states: ARB, LOCK0, LOCK1.
- ARB state:
  - One request pending: grant it.
  - Both pending: grant the requester rr_ptr points to. After any grant, rr_ptr = the other requester.
  - If the granted requester also has lock_i = 1, go to LOCK<i> with lock_cnt = 1.
- LOCK<i> state:
  - Only requester i may be granted. The other requester's req is ignored and gets no gnt.
  - req_i && lock_i: grant, lock_cnt++.
  - lock_i = 0: return to ARB. If req_i is still high, grant it this cycle as the final locked transfer.
  - req_i low with lock_i high: no grant; stay in the state. lock_cnt is unchanged.
- Lock limit:
  - In LOCK<i>, when lock_cnt == MAX_LOCK and the other requester is requesting, do not grant i.
  - Go to ARB with rr_ptr = other. The other requester then wins the next cycle.
  - If the other requester is not requesting, lock_cnt saturates at MAX_LOCK and the lock continues.
- Simultaneous events:
  - A read return and a new grant in the same cycle are independent. The registered tag always reflects the previous cycle's grant.
- Reset mid-operation:
  - A pending read return is dropped; rvalid is not asserted after reset releases.
  - Requesters must reissue.
- Address checking: none; the full address is passed through. Memory uses bits [15:0].

Decomposition:
- ReadWriteModes comes from MemoryModesPackage; reuse it, do not redefine it.
- Add ArbStates enum (ARB, LOCK0, LOCK1) to a new MemArbPackage, alongside the requester index constants REQ_CPU = 0 and REQ_DBG = 1.
- One sub-module, rr_pick2: a two-input round-robin picker (req[1:0], ptr → gnt one-hot). It is combinational and reused for future bus arbiters.

Test Plan:
- CPU-only load: req_i = 01, WORD load, addr 0x0000_0010. Required: gnt = 01 the same cycle; mem_readMode = WORD, mem_address = 0x10. Next cycle: rvalid = 01 and rdata = mem_dataOutput.
- Both requesting stores, 4 cycles, no lock: grants alternate 01, 10, 01, 10 starting from rr_ptr = 0. mem_writeMode follows each granted requester's mode. rvalid stays 0.
- DBG lock burst, MAX_LOCK = 4, CPU requesting throughout: DBG granted 4 consecutive cycles, then 1 cycle with no grant, then CPU granted. The FSM path is LOCK1 → ARB.
- Lock release with pending req: DBG drops lock_i while req_i is still high. Required: final DBG grant that cycle; FSM in ARB next cycle; CPU granted if requesting.
- Back-to-back loads CPU then DBG: tags route correctly. rvalid is 01 then 10 on consecutive cycles, each with the matching mem_dataOutput.
- Async reset asserted the cycle after a granted load: rvalid is never asserted for that load. All outputs are at reset values immediately; FSM is in ARB after release.
